// File: rtl/mem_access_arbiter.sv
// Front end of the main memory: round-robin arbitration between the fetch and data
// requesters, one access at a time on the enable/finish handshake, with a finish watchdog.
module mem_access_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 31,
  parameter int TIMEOUT    = 15,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_finish,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t           state;
  logic             port_d;   // 1 = current access belongs to the data port
  logic             we_r;
  logic             pref_d;   // round-robin pointer: data port wins the next tie
  logic [CNT_W-1:0] cnt;
  logic             grant_d;

  always_comb begin
    grant_d = d_req & (~if_req | pref_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      port_d           <= 1'b0;
      we_r             <= 1'b0;
      pref_d           <= DATA_FIRST;
      cnt              <= '0;
      if_ack           <= 1'b0;
      d_ack            <= 1'b0;
      if_rdata         <= '0;
      d_rdata          <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_addr         <= '0;
      mem_write_data   <= '0;
      timeout_err      <= 1'b0;
    end else begin
      case (state)
        // Grant: the loser of the last tie wins this one; the pointer moves on every grant.
        IDLE: begin
          if (if_req | d_req) begin
            state            <= ACCESS;
            port_d           <= grant_d;
            pref_d           <= ~grant_d;
            we_r             <= grant_d & d_we;
            mem_addr         <= grant_d ? d_addr : if_addr;
            if (grant_d & d_we) begin
              mem_write_data <= d_wdata;
            end
            mem_write_enable <= grant_d & d_we;
            mem_read_enable  <= ~(grant_d & d_we);
            cnt              <= '0;
          end
        end
        // Enables stay up through the finish cycle; the watchdog aborts straight to RESP.
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_finish) begin
            state            <= CAPTURE;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state            <= RESP;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            timeout_err      <= 1'b1;
            if (port_d) begin
              d_ack  <= 1'b1;
            end else begin
              if_ack <= 1'b1;
            end
          end
        end
        // Memory read word is valid the cycle after finish.
        CAPTURE: begin
          state <= RESP;
          if (port_d) begin
            d_ack <= 1'b1;
            if (!we_r) begin
              d_rdata <= mem_read_data;
            end
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= mem_read_data;
          end
        end
        RESP: begin
          state  <= IDLE;
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          cnt    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
